// File: rtl/spectral_peak_fsm.sv
// Frame controller: captures one FFT frame, scans a bin window for the peak
// approximate magnitude, reports peak/voiced and serves the buffer for readout.
module spectral_peak_fsm #(
  parameter int DATA_W = 18,
  parameter int LOG2_N = 9,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fft_done,
  input  logic [LOG2_N-1:0]     fft_address,
  input  logic                  fft_read_valid,
  input  logic [2*DATA_W-1:0]   fft_data,
  input  logic [LOG2_N-1:0]     bin_lo,
  input  logic [LOG2_N-1:0]     bin_hi,
  input  logic [DATA_W-1:0]     mag_thresh,
  output logic                  busy,
  output logic                  done,
  output logic [LOG2_N-1:0]     peak_index,
  output logic [DATA_W-1:0]     peak_mag,
  output logic                  voiced,
  output logic [CNT_W-1:0]      overrun_count,
  input  logic                  rd_en,
  input  logic [LOG2_N-1:0]     rd_addr,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  rd_valid
);

  // state     | meaning
  // S_IDLE    | waiting for fft_done; buffer readout allowed
  // S_CAPTURE | writing valid samples into the buffer until bin N-1
  // S_SCAN    | read -> magnitude -> compare pipeline over the window
  // S_REPORT  | results registered, done pulse high, one cycle
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SCAN, S_REPORT} state_t;

  localparam int N     = 1 << LOG2_N;
  localparam int TMR_W = LOG2_N + 2;

  state_t                r_state, w_next;
  logic [2*DATA_W-1:0]   r_mem [N];
  logic [2*DATA_W-1:0]   r_rdata;
  logic [LOG2_N-1:0]     r_lo, r_hi;
  logic [DATA_W-1:0]     r_thresh;
  logic [TMR_W-1:0]      r_tmr;
  logic [LOG2_N-1:0]     r_scan_addr;
  logic                  r_v1, r_v2;
  logic [LOG2_N-1:0]     r_idx1, r_idx2;
  logic [DATA_W-1:0]     r_mag2;
  logic [DATA_W-1:0]     r_max;
  logic [LOG2_N-1:0]     r_max_idx;
  logic                  r_done;
  logic [LOG2_N-1:0]     r_peak_index;
  logic [DATA_W-1:0]     r_peak_mag;
  logic                  r_voiced;
  logic [CNT_W-1:0]      r_ovr;
  logic                  r_rd_valid;

  logic                  w_last_wr, w_issue, w_mem_we, w_mem_re;
  logic [LOG2_N-1:0]     w_raddr;
  logic [LOG2_N:0]       w_width;
  logic signed [DATA_W-1:0] w_re, w_im;
  logic [DATA_W-1:0]     w_a, w_b, w_max_ab, w_min_ab, w_mag;

  assign w_last_wr = fft_read_valid && (&fft_address);
  // Timer counts down W+2..0; reads are issued while it is above 2 (W reads).
  assign w_issue   = (r_state == S_SCAN) && (r_tmr > TMR_W'(2));
  assign w_width   = (r_hi >= r_lo) ? ({1'b0, r_hi} - {1'b0, r_lo} + (LOG2_N+1)'(1))
                                    : '0;
  assign w_mem_we  = !reset && (r_state == S_CAPTURE) && fft_read_valid;
  assign w_mem_re  = w_issue || (rd_en && (r_state == S_IDLE));
  assign w_raddr   = w_issue ? r_scan_addr : rd_addr;

  assign w_re      = r_rdata[2*DATA_W-1:DATA_W];
  assign w_im      = r_rdata[DATA_W-1:0];
  assign w_a       = w_re[DATA_W-1] ? (~w_re + DATA_W'(1)) : w_re;
  assign w_b       = w_im[DATA_W-1] ? (~w_im + DATA_W'(1)) : w_im;
  assign w_max_ab  = (w_a > w_b) ? w_a : w_b;
  assign w_min_ab  = (w_a > w_b) ? w_b : w_a;
  assign w_mag     = w_max_ab + (w_min_ab >> 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (fft_done) w_next = S_CAPTURE;
      S_CAPTURE: if (w_last_wr) w_next = S_SCAN;
      S_SCAN:    if (r_tmr == '0) w_next = S_REPORT;
      S_REPORT:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[fft_address] <= fft_data;
    if (w_mem_re) r_rdata <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lo         <= '0;
      r_hi         <= '0;
      r_thresh     <= '0;
      r_tmr        <= '0;
      r_scan_addr  <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_idx1       <= '0;
      r_idx2       <= '0;
      r_mag2       <= '0;
      r_max        <= '0;
      r_max_idx    <= '0;
      r_done       <= 1'b0;
      r_peak_index <= '0;
      r_peak_mag   <= '0;
      r_voiced     <= 1'b0;
      r_ovr        <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done     <= 1'b0;
      r_rd_valid <= rd_en && (r_state == S_IDLE);
      r_v1       <= w_issue;
      r_idx1     <= r_scan_addr;
      r_v2       <= r_v1;
      r_idx2     <= r_idx1;
      r_mag2     <= w_mag;
      if (w_issue) r_scan_addr <= r_scan_addr + LOG2_N'(1);
      if (r_state == S_SCAN) r_tmr <= r_tmr - TMR_W'(1);
      if (r_v2 && (r_mag2 > r_max)) begin
        r_max     <= r_mag2;
        r_max_idx <= r_idx2;
      end
      if (fft_done && (r_state != S_IDLE) && (r_ovr != '1))
        r_ovr <= r_ovr + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (fft_done) begin
            r_lo     <= bin_lo;
            r_hi     <= bin_hi;
            r_thresh <= mag_thresh;
          end
        end
        S_CAPTURE: begin
          if (w_last_wr) begin
            r_tmr       <= {1'b0, w_width} + TMR_W'(2);
            r_scan_addr <= r_lo;
            r_max       <= '0;
            r_max_idx   <= r_lo;
          end
        end
        S_SCAN: begin
          if (r_tmr == '0) begin
            r_peak_index <= r_max_idx;
            r_peak_mag   <= r_max;
            r_voiced     <= (r_max > r_thresh);
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign peak_index    = r_peak_index;
  assign peak_mag      = r_peak_mag;
  assign voiced        = r_voiced;
  assign overrun_count = r_ovr;
  assign rd_data       = r_rdata;
  assign rd_valid      = r_rd_valid;

endmodule

// File: tb/tb_spectral_peak_fsm.sv
// Bench for spectral_peak_fsm: directed and random frames checked against a
// plain arithmetic peak model over a bench-side copy of the frame.
module tb_spectral_peak_fsm;
  localparam int DATA_W = 18;
  localparam int LOG2_N = 9;
  localparam int CNT_W  = 8;
  localparam int N      = 512;

  logic                clk = 1'b0;
  logic                reset;
  logic                fft_done;
  logic [LOG2_N-1:0]   fft_address;
  logic                fft_read_valid;
  logic [2*DATA_W-1:0] fft_data;
  logic [LOG2_N-1:0]   bin_lo, bin_hi;
  logic [DATA_W-1:0]   mag_thresh;
  logic                busy, done, voiced, rd_en, rd_valid;
  logic [LOG2_N-1:0]   peak_index, rd_addr;
  logic [DATA_W-1:0]   peak_mag;
  logic [CNT_W-1:0]    overrun_count;
  logic [2*DATA_W-1:0] rd_data;

  always #5 clk = ~clk;

  spectral_peak_fsm #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fft_done(fft_done), .fft_address(fft_address),
    .fft_read_valid(fft_read_valid), .fft_data(fft_data), .bin_lo(bin_lo),
    .bin_hi(bin_hi), .mag_thresh(mag_thresh), .busy(busy), .done(done),
    .peak_index(peak_index), .peak_mag(peak_mag), .voiced(voiced),
    .overrun_count(overrun_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  int fre [N];
  int fim [N];
  int n_chk = 0;
  int n_bad = 0;
  int exp_ovr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rnd_s18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  function automatic logic [2*DATA_W-1:0] pack(input int a);
    logic [DATA_W-1:0] re, im;
    re = DATA_W'(fre[a]);
    im = DATA_W'(fim[a]);
    return {re, im};
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin fre[i] = 0; fim[i] = 0; end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin fre[i] = rnd_s18(); fim[i] = rnd_s18(); end
  endtask

  // Peak of the window: largest max+min/2 magnitude, first index wins ties.
  task automatic model(input int lo, input int hi, input int thr,
                       output int idx, output int mag, output int vcd);
    int a, b, m;
    idx = lo;
    mag = 0;
    for (int i = lo; i <= hi; i++) begin
      a = iabs(fre[i]);
      b = iabs(fim[i]);
      m = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
      if (m > mag) begin mag = m; idx = i; end
    end
    vcd = (mag > thr) ? 1 : 0;
  endtask

  task automatic capture(input int lo, input int hi, input int thr,
                         input bit spam, input bit gaps, input int abort_at);
    fft_done = 1'b1;
    bin_lo = LOG2_N'(lo);
    bin_hi = LOG2_N'(hi);
    mag_thresh = DATA_W'(thr);
    tick();
    fft_done = 1'b0;
    chk("busy_rise", busy, 1);
    bin_lo = LOG2_N'($urandom);
    bin_hi = LOG2_N'($urandom);
    mag_thresh = DATA_W'($urandom);
    for (int a = 0; a < N; a++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        fft_read_valid = 1'b0;
        fft_address = LOG2_N'($urandom);
        fft_data = 36'($urandom);
        tick();
      end
      if (a == abort_at) reset = 1'b1;
      fft_read_valid = 1'b1;
      fft_address = LOG2_N'(a);
      fft_data = pack(a);
      if (spam && a < 300) begin
        fft_done = 1'b1;
        rd_en = 1'b1;
        rd_addr = LOG2_N'(a);
        exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
      end
      tick();
      fft_done = 1'b0;
      rd_en = 1'b0;
      if (spam && a == 299) chk("rd_busy", rd_valid, 0);
      if (a == abort_at) begin
        reset = 1'b0;
        fft_read_valid = 1'b0;
        return;
      end
    end
    fft_read_valid = 1'b0;
  endtask

  task automatic result(input int lo, input int hi, input int thr, input int elapsed);
    int idx, mag, vcd, w, k, got;
    model(lo, hi, thr, idx, mag, vcd);
    w = (lo <= hi) ? hi - lo + 1 : 0;
    k = elapsed;
    got = -1;
    while (k < w + 23 && got < 0) begin
      tick();
      k++;
      if (done) got = k;
    end
    chk("done_lat", got, w + 3);
    if (got >= 0) begin
      chk("peak_index", peak_index, idx);
      chk("peak_mag", peak_mag, mag);
      chk("voiced", voiced, vcd);
      tick();
      chk("done_pulse", done, 0);
      chk("busy_fall", busy, 0);
      chk("overrun", overrun_count, exp_ovr);
    end
  endtask

  task automatic readout(input int a);
    rd_en = 1'b1;
    rd_addr = LOG2_N'(a);
    tick();
    rd_en = 1'b0;
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, pack(a));
  endtask

  initial begin
    int lo, hi, thr, t, ndone;
    int thrs [3] = '{600, 499, 500};
    reset = 1'b1;
    fft_done = 1'b0;
    fft_address = '0;
    fft_read_valid = 1'b0;
    fft_data = '0;
    bin_lo = '0;
    bin_hi = '0;
    mag_thresh = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_index", peak_index, 0);
    chk("rst_mag", peak_mag, 0);
    chk("rst_voiced", voiced, 0);
    chk("rst_ovr", overrun_count, 0);
    chk("rst_rdv", rd_valid, 0);

    clear_frame();
    fre[100] = 3000; fim[100] = -4000;
    capture(0, 511, 1000, 0, 0, -1);
    result(0, 511, 1000, 0);
    readout(100);
    readout(7);

    clear_frame();
    fre[20] = 500; fre[30] = 500;
    for (int i = 0; i < 3; i++) begin
      capture(0, 511, thrs[i], 0, 0, -1);
      result(0, 511, thrs[i], 0);
    end

    clear_frame();
    fre[5] = 10000; fre[200] = 2000;
    capture(50, 300, 1000, 0, 0, -1);
    result(50, 300, 1000, 0);
    fre[60] = -131072; fim[60] = -131072;
    capture(50, 300, 1000, 0, 1, -1);
    result(50, 300, 1000, 0);
    capture(300, 50, 1000, 0, 0, -1);
    result(300, 50, 1000, 0);

    rand_frame();
    capture(10, 400, 150000, 0, 1, -1);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    exp_ovr++;
    result(10, 400, 150000, 1);

    rand_frame();
    capture(0, 511, 100000, 1, 0, -1);
    result(0, 511, 100000, 0);

    rand_frame();
    capture(0, 511, 0, 0, 0, 200);
    exp_ovr = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_index", peak_index, 0);
    chk("abort_mag", peak_mag, 0);
    chk("abort_voiced", voiced, 0);
    chk("abort_ovr", overrun_count, 0);
    chk("abort_rdv", rd_valid, 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    rand_frame();
    capture(3, 480, 120000, 0, 0, -1);
    result(3, 480, 120000, 0);

    for (int f = 0; f < 6; f++) begin
      rand_frame();
      lo = $urandom_range(0, N - 1);
      hi = $urandom_range(0, N - 1);
      if (hi < lo && $urandom_range(0, 3) != 0) begin t = lo; lo = hi; hi = t; end
      thr = $urandom_range(0, 200000);
      capture(lo, hi, thr, 0, 1, -1);
      result(lo, hi, thr, 0);
      readout($urandom_range(0, N - 1));
      readout($urandom_range(0, N - 1));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
